// File: rtl/key_pkg.sv
// Shared definitions for the keyboard-to-tank key router: direction keycodes,
// the per-player direction vector type and the report-processing FSM states.
package key_pkg;

  // Player 1 direction keys (WASD).
  localparam logic [7:0] KC_W     = 8'h1A;
  localparam logic [7:0] KC_S     = 8'h16;
  localparam logic [7:0] KC_A     = 8'h04;
  localparam logic [7:0] KC_D     = 8'h07;

  // Player 2 direction keys (arrow cluster).
  localparam logic [7:0] KC_UP    = 8'h52;
  localparam logic [7:0] KC_DOWN  = 8'h51;
  localparam logic [7:0] KC_LEFT  = 8'h50;
  localparam logic [7:0] KC_RIGHT = 8'h4F;

  // Phantom-state code the keyboard reports when too many keys are down.
  localparam logic [7:0] KEY_ROLLOVER = 8'h01;

  // Direction set, bit order {up, down, left, right}.
  typedef logic [3:0] dir_t;

  localparam dir_t DIR_UP    = 4'b1000;
  localparam dir_t DIR_DOWN  = 4'b0100;
  localparam dir_t DIR_LEFT  = 4'b0010;
  localparam dir_t DIR_RIGHT = 4'b0001;
  localparam dir_t DIR_NONE  = 4'b0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // One-hot of the highest-priority held direction: up > down > left > right.
  function automatic dir_t prio_pick(input dir_t d);
    dir_t r;
    r = DIR_NONE;
    if (d[3])      r = DIR_UP;
    else if (d[2]) r = DIR_DOWN;
    else if (d[1]) r = DIR_LEFT;
    else if (d[0]) r = DIR_RIGHT;
    return r;
  endfunction

endpackage

// File: rtl/key_player_track.sv
// Per-player key tracker: turns a captured HID report into the held direction
// set and resolves it to a single keycode with last-pressed-wins semantics,
// falling back to a still-held key (by fixed priority) when the latest is released.
module key_player_track
  import key_pkg::*;
#(
  parameter int              NUM_SLOTS = 6,
  parameter int              KEY_W     = 8,
  parameter logic [KEY_W-1:0] KEY_UP    = 8'h1A,
  parameter logic [KEY_W-1:0] KEY_DOWN  = 8'h16,
  parameter logic [KEY_W-1:0] KEY_LEFT  = 8'h04,
  parameter logic [KEY_W-1:0] KEY_RIGHT = 8'h07
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       decode_en,
  input  logic                       commit_en,
  input  logic [NUM_SLOTS*KEY_W-1:0] report_keys,
  output logic [KEY_W-1:0]           last
);

  dir_t             held;
  dir_t             held_nxt;
  dir_t             slot_dir;
  dir_t             held_dec;
  dir_t             new_press_dec;
  dir_t             last_dir;
  dir_t             fallback_dir;
  logic             found;
  logic             last_still_held;
  logic [KEY_W-1:0] first_new;
  logic [KEY_W-1:0] first_new_dec;
  logic [KEY_W-1:0] fallback_code;
  logic [KEY_W-1:0] last_nxt;

  // Non-direction keys map to an empty set, so they drop out of every OR below.
  function automatic dir_t dir_of(input logic [KEY_W-1:0] code);
    return {code == KEY_UP, code == KEY_DOWN, code == KEY_LEFT, code == KEY_RIGHT};
  endfunction

  function automatic logic [KEY_W-1:0] code_of(input dir_t d);
    logic [KEY_W-1:0] c;
    c = '0;
    if (d[3])      c = KEY_UP;
    else if (d[2]) c = KEY_DOWN;
    else if (d[1]) c = KEY_LEFT;
    else if (d[0]) c = KEY_RIGHT;
    return c;
  endfunction

  // Scan slots: union of held directions, and the lowest-slot key not held before.
  always_comb begin
    held_nxt  = DIR_NONE;
    slot_dir  = DIR_NONE;
    first_new = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_dir = dir_of(report_keys[i*KEY_W +: KEY_W]);
      held_nxt = held_nxt | slot_dir;
      if (!found && ((slot_dir & ~held) != DIR_NONE)) begin
        first_new = report_keys[i*KEY_W +: KEY_W];
        found     = 1'b1;
      end
    end
  end

  // Resolve the next "last" key from the decoded report.
  always_comb begin
    last_dir        = dir_of(last);
    last_still_held = (last_dir & held_dec) != DIR_NONE;
    fallback_dir    = prio_pick(held_dec);
    fallback_code   = code_of(fallback_dir);
    if (new_press_dec != DIR_NONE) begin
      last_nxt = first_new_dec;
    end else if (last_still_held) begin
      last_nxt = last;
    end else begin
      // fallback_code is zero when nothing is held.
      last_nxt = fallback_code;
    end
  end

  // Decode stage snapshot, then commit held/last together.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      held          <= DIR_NONE;
      last          <= '0;
      held_dec      <= DIR_NONE;
      new_press_dec <= DIR_NONE;
      first_new_dec <= '0;
    end else begin
      if (decode_en) begin
        held_dec      <= held_nxt;
        new_press_dec <= held_nxt & ~held;
        first_new_dec <= first_new;
      end
      if (commit_en) begin
        held <= held_dec;
        last <= last_nxt;
      end
    end
  end

endmodule

// File: rtl/key_router.sv
// Routes HID boot-keyboard reports to two tanks: WASD for player 1, arrows for
// player 2. Each report goes IDLE -> DECODE -> COMMIT; outputs change on frame ticks.
module key_router
  import key_pkg::*;
#(
  parameter int NUM_SLOTS = 6,
  parameter int KEY_W     = 8
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       report_valid,
  output logic                       report_ready,
  input  logic [NUM_SLOTS*KEY_W-1:0] report_keys,
  input  logic                       frame_tick,
  output logic [KEY_W-1:0]           keycode_p1,
  output logic [KEY_W-1:0]           keycode_p2,
  output logic                       rollover_err
);

  state_t                     state;
  logic [NUM_SLOTS*KEY_W-1:0] report_q;
  logic                       rollover_hit;
  logic                       rollover_q;
  logic                       accept;
  logic                       decode_en;
  logic                       commit_en;
  logic [KEY_W-1:0]           last_p1;
  logic [KEY_W-1:0]           last_p2;

  assign accept    = report_valid & report_ready;
  assign decode_en = (state == DECODE);
  // A rollover report must leave held/last untouched, so commit is suppressed.
  assign commit_en = (state == COMMIT) && !rollover_q;

  // Any slot carrying the phantom code poisons the whole report.
  always_comb begin
    rollover_hit = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (report_q[i*KEY_W +: KEY_W] == KEY_ROLLOVER) rollover_hit = 1'b1;
    end
  end

  // Report FSM with registered ready and sticky rollover flag.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state        <= IDLE;
      report_ready <= 1'b1;
      report_q     <= '0;
      rollover_q   <= 1'b0;
      rollover_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            report_q     <= report_keys;
            report_ready <= 1'b0;
            state        <= DECODE;
          end
        end
        DECODE: begin
          rollover_q <= rollover_hit;
          state      <= COMMIT;
        end
        COMMIT: begin
          if (rollover_q) rollover_err <= 1'b1;
          report_ready <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          report_ready <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

  key_player_track #(
    .NUM_SLOTS (NUM_SLOTS),
    .KEY_W     (KEY_W),
    .KEY_UP    (KC_W),
    .KEY_DOWN  (KC_S),
    .KEY_LEFT  (KC_A),
    .KEY_RIGHT (KC_D)
  ) u_track_p1 (
    .Clk         (Clk),
    .Reset       (Reset),
    .decode_en   (decode_en),
    .commit_en   (commit_en),
    .report_keys (report_q),
    .last        (last_p1)
  );

  key_player_track #(
    .NUM_SLOTS (NUM_SLOTS),
    .KEY_W     (KEY_W),
    .KEY_UP    (KC_UP),
    .KEY_DOWN  (KC_DOWN),
    .KEY_LEFT  (KC_LEFT),
    .KEY_RIGHT (KC_RIGHT)
  ) u_track_p2 (
    .Clk         (Clk),
    .Reset       (Reset),
    .decode_en   (decode_en),
    .commit_en   (commit_en),
    .report_keys (report_q),
    .last        (last_p2)
  );

  // Frame-rate output latch; a tick coinciding with COMMIT takes the old value.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      keycode_p1 <= '0;
      keycode_p2 <= '0;
    end else if (frame_tick) begin
      keycode_p1 <= last_p1;
      keycode_p2 <= last_p2;
    end
  end

endmodule

// File: doc/key_router.md
Name: key_router

Overview:
- Sits between the USB keyboard report path and the two tank instances.
- Converts a 6-slot HID boot-keyboard report into one stable direction keycode per player: player 1 uses WASD, player 2 uses the arrow keys.
- Resolves multiple held keys with last-pressed-wins and reverts to a still-held key on release.
- Updates its outputs only on a frame tick, so the tanks see one keycode per frame.

Parameters:
- NUM_SLOTS, 6, keycode slots per HID report.
- KEY_W, 8, keycode width in bits.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-low reset. Sampled on the rising edge of Clk; 0 = reset.
- report_valid  in  1  new report present on report_keys.
- report_ready  out  1  block can accept a report.
- report_keys  in  NUM_SLOTS*KEY_W  slot i is bits [8i+7:8i]; 8'h00 = empty slot.
- frame_tick  in  1  one-Clk pulse per video frame, already synchronised to Clk.
- keycode_p1  out  8  player 1 keycode: 8'h04, 8'h07, 8'h16, 8'h1A, or 8'h00.
- keycode_p2  out  8  player 2 keycode: 8'h4F, 8'h50, 8'h51, 8'h52, or 8'h00.
- rollover_err  out  1  sticky flag; set when a report containing 8'h01 is seen.

Behaviour:
- Reset (Reset=0 at a rising edge):
  - keycode_p1=0, keycode_p2=0, rollover_err=0.
  - held_p1=held_p2=4'b0000, last_p1=last_p2=0.
  - FSM returns to IDLE and report_ready=1 from the next cycle.
  - Any report mid-processing is discarded.
- Handshake:
  - A report is accepted on a cycle where report_valid & report_ready.
  - report_keys is captured into a register on that cycle.
  - report_ready is 1 only in IDLE.
- FSM states:
  - IDLE: on accept, go to DECODE.
  - DECODE (1 cycle): build next_held_pX from the 4 direction bits per player. Bit order is {up, down, left, right}: W/S/A/D for player 1, 52/51/50/4F for player 2. Compute new_press = next_held & ~held. Go to COMMIT.
  - COMMIT (1 cycle): update held and last (rules below), then go to IDLE.
- Timing:
  - Accept at cycle N, COMMIT in cycle N+2, report_ready high again at N+3.
  - Sustained throughput is one report per 3 cycles.
- Rollover:
  - If any slot equals 8'h01, the report is ignored: held and last are unchanged and rollover_err is set.
  - rollover_err stays set until reset.
- last_pX update in COMMIT, per player independently:
  - If new_press is nonzero, last = the newly pressed key in the lowest-numbered slot.
  - Else if last is still held, last is unchanged.
  - Else if any key is held, last = the highest-priority held key, priority up > down > left > right.
  - Else last = 8'h00.
- Duplicate keycodes across slots count once.
- Non-direction keycodes are ignored.
- Output update:
  - On a frame_tick cycle, keycode_pX <= last_pX; visible one cycle after the tick.
  - Outputs hold between ticks.
- Simultaneous events:
  - frame_tick in the same cycle as COMMIT latches the pre-COMMIT last value; the new value appears at the next tick.
  - frame_tick during reset is ignored.
- Opposing keys both held (e.g. W+S) follow the same last-pressed rule; there is no cancellation.

Decomposition:
- Shared package key_pkg holds:
  - localparams for the 8 direction keycodes and KEY_ROLLOVER=8'h01.
  - typedef dir_t = logic [3:0] in {up, down, left, right} order.
  - the FSM state enum {IDLE, DECODE, COMMIT}.
- One sub-module, key_player_track, instantiated twice with keycode constants as parameters.
  - Contains held/last registers, new-press detect, fallback priority.
- Top level contains the FSM, report register, rollover detect and output latch.

Test Plan:
- Reset, then report {07,00,00,00,00,00}, then frame_tick → report_ready=1 from reset exit; keycode_p1=8'h07 one cycle after the tick; keycode_p2=8'h00.
- Hold W (1A); next report {1A,04,...}; next report {04} only; tick after each → keycode_p1 shows 1A, then 04, then 04.
- Report {1A,16} with both new; next report {16} → keycode_p1 is 1A (slot 0 wins), then 16 (fallback to held S).
- Report {52,1A} → keycode_p1=1A, keycode_p2=52 on the same tick. Then report {00…} → both outputs 00 after the next tick.
- Report {01,01,01,01,01,01} after S is held → rollover_err=1 and keycode_p1 stays 16. Then assert Reset=0 for one cycle mid-DECODE → all outputs 0 and report_ready=1 the cycle after Reset returns high.
- frame_tick pulsed in the COMMIT cycle of an accept → the output shows the old value; the next tick shows the new value. Also check report_ready is low for exactly 2 cycles after each accept.
